tlc_vehicle_detector: RTL and testbench

Conditions the raw farm-road loop-detector signal and produces the clean vehicle-request input consumed by the traffic-light controller.
- Synchronises and debounces the sensor.
- Counts arrivals until the controller acknowledges service.
- Flags a stuck-on sensor and, while the fault lasts, requests service fail-safe.

It sits directly upstream of the light controller: `car_req` drives the controller's sensor input `C`.

---
 rtl/tlc_pkg.sv | 14 +
 rtl/tlc_vehicle_detector_if.sv | 24 ++
 rtl/tlc_debounce.sv | 55 +++++
 rtl/tlc_vehicle_detector.sv | 109 ++++++++++
 tb/tb_tlc_vehicle_detector.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// Shared types and default constants for the traffic-light controller blocks.
package tlc_pkg;

  localparam int TLC_DEBOUNCE_CYCLES = 4;
  localparam int TLC_STUCK_CYCLES    = 200;
  localparam int TLC_CNT_W           = 4;

  typedef enum logic [1:0] {
    DET_IDLE  = 2'd0,
    DET_OCC   = 2'd1,
    DET_FAULT = 2'd2
  } det_state_t;

endpackage

// File: rtl/tlc_vehicle_detector_if.sv
// Detector <-> controller signal bundle; master drives the sensor/ack side.
interface tlc_vehicle_detector_if import tlc_pkg::*; #(
  parameter int CNT_W = TLC_CNT_W
) ();

  logic             ena;
  logic             sensor_raw;
  logic             serve_ack;
  logic             car_req;
  logic [CNT_W-1:0] car_count;
  logic             vehicle_pulse;
  logic             fault;

  modport master (
    output ena, sensor_raw, serve_ack,
    input  car_req, car_count, vehicle_pulse, fault
  );

  modport slave (
    input  ena, sensor_raw, serve_ack,
    output car_req, car_count, vehicle_pulse, fault
  );

endinterface

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser plus debounce filter for the loop-detector input.
module tlc_debounce import tlc_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = TLC_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic sensor_raw,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            s1;
  logic            s2;
  logic [DB_W-1:0] db_cnt;
  logic            toggle;

  // rise/fall are asserted on the edge where the filtered level will flip
  assign toggle = ena && (s2 != filt) && (db_cnt == DB_LAST);
  assign rise   = toggle && !filt;
  assign fall   = toggle && filt;

  // synchroniser runs regardless of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sensor_raw;
      s2 <= s1;
    end
  end

  // count consecutive disagreeing samples, flip the filtered level when enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (ena) begin
      if (s2 == filt) begin
        db_cnt <= '0;
      end else if (toggle) begin
        db_cnt <= '0;
        filt   <= ~filt;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/tlc_vehicle_detector.sv
// Farm-road vehicle detector: debounced arrivals, waiting queue, stuck-sensor fail-safe.
module tlc_vehicle_detector import tlc_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = TLC_DEBOUNCE_CYCLES,
  parameter int CNT_W           = TLC_CNT_W,
  parameter int STUCK_CYCLES    = TLC_STUCK_CYCLES
) (
  input logic                  clk,
  input logic                  rst_n,
  tlc_vehicle_detector_if.slave bus
);

  localparam int OCC_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(STUCK_CYCLES);

  det_state_t       state;
  det_state_t       state_nxt;
  logic             filt;
  logic             rise;
  logic             fall;
  logic             arrival;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_inc;
  logic [CNT_W-1:0] car_count;
  logic             vehicle_pulse;
  logic             fault;
  logic             car_req;

  tlc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (bus.ena),
    .sensor_raw (bus.sensor_raw),
    .filt       (filt),
    .rise       (rise),
    .fall       (fall)
  );

  // rise already carries ena; only an idle detector counts a new vehicle
  assign arrival = rise && (state == DET_IDLE);
  assign occ_inc = occ + OCC_W'(1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DET_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: a falling filtered edge takes priority over reaching the stuck limit
  always_comb begin
    state_nxt = state;
    unique case (state)
      DET_IDLE:  if (rise) state_nxt = DET_OCC;
      DET_OCC: begin
        if (fall) begin
          state_nxt = DET_IDLE;
        end else if (bus.ena && filt && (occ_inc == OCC_LIMIT)) begin
          state_nxt = DET_FAULT;
        end
      end
      DET_FAULT: if (fall) state_nxt = DET_IDLE;
      default:   state_nxt = DET_IDLE;
    endcase
  end

  // output decode from registered state and queue
  always_comb begin
    fault   = (state == DET_FAULT);
    car_req = (|car_count) || fault;
  end

  // occupancy timer, waiting-vehicle queue and arrival pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ           <= '0;
      car_count     <= '0;
      vehicle_pulse <= 1'b0;
    end else begin
      vehicle_pulse <= arrival;
      if (bus.ena) begin
        if (arrival) begin
          occ <= '0;
        end else if ((state == DET_OCC) && filt) begin
          occ <= occ_inc;
        end

        if (arrival) begin
          if (bus.serve_ack) begin
            car_count <= CNT_W'(1);
          end else if (car_count != '1) begin
            car_count <= car_count + CNT_W'(1);
          end
        end else if (bus.serve_ack) begin
          car_count <= '0;
        end
      end
    end
  end

  assign bus.car_req       = car_req;
  assign bus.car_count     = car_count;
  assign bus.vehicle_pulse = vehicle_pulse;
  assign bus.fault         = fault;

endmodule

// File: tb/tb_tlc_vehicle_detector.sv
// Self-checking bench: window-based behavioural model plus directed literal checks.
module tb_tlc_vehicle_detector;

  localparam int DB    = 4;
  localparam int CW    = 4;
  localparam int STUCK = 200;
  localparam int MAXC  = 15;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   pulse_cnt;
  bit   chk_en;

  tlc_vehicle_detector_if #(.CNT_W(CW)) bus ();

  tlc_vehicle_detector #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(CW),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input int exp);
    tests++;
    if (got !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: the filtered level flips once the last DB enabled
  // synchronised samples all disagree with it.
  logic m_win[$];
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_filt = 1'b0, m_pulse = 1'b0;
  logic m_fault = 1'b0, m_occd = 1'b0;
  int   m_occ_cyc = 0;
  int   m_count = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_win.delete();
      m_s1 = 1'b0; m_s2 = 1'b0; m_filt = 1'b0; m_pulse = 1'b0;
      m_fault = 1'b0; m_occd = 1'b0; m_occ_cyc = 0; m_count = 0;
    end else begin
      bit arr;
      bit dep;
      bit ok;
      arr = 1'b0;
      dep = 1'b0;
      if (bus.ena) begin
        m_win.push_back(m_s2);
        if (m_win.size() > DB) void'(m_win.pop_front());
        if (m_win.size() == DB) begin
          ok = 1'b1;
          foreach (m_win[i]) if (m_win[i] == m_filt) ok = 1'b0;
          if (ok) begin
            m_filt = !m_filt;
            m_win.delete();
            if (m_filt) arr = 1'b1;
            else        dep = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.sensor_raw;
      m_pulse = arr;
      if (arr) begin
        m_occd = 1'b1;
        m_occ_cyc = 0;
      end else if (dep) begin
        m_occd = 1'b0;
        m_fault = 1'b0;
      end else if (m_occd && bus.ena && !m_fault) begin
        m_occ_cyc++;
        if (m_occ_cyc >= STUCK) m_fault = 1'b1;
      end
      if (bus.ena) begin
        if (arr) m_count = bus.serve_ack ? 1 : ((m_count < MAXC) ? m_count + 1 : MAXC);
        else if (bus.serve_ack) m_count = 0;
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("pulse", bus.vehicle_pulse, int'(m_pulse));
      check("count", bus.car_count, m_count);
      check("fault", bus.fault, int'(m_fault));
      check("req", bus.car_req, ((m_count != 0) || m_fault) ? 1 : 0);
      if (bus.vehicle_pulse) pulse_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    tests = 0; fails = 0; pulse_cnt = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    bus.ena = 1'b1; bus.sensor_raw = 1'b0; bus.serve_ack = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req", bus.car_req, 0);
    check("rst_count", bus.car_count, 0);
    check("rst_pulse", bus.vehicle_pulse, 0);
    check("rst_fault", bus.fault, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // clean arrival: pulse exactly at edge 5
    bus.sensor_raw = 1'b1;
    repeat (5) step();
    check("arr_e4_pulse", bus.vehicle_pulse, 0);
    check("arr_e4_count", bus.car_count, 0);
    step();
    check("arr_e5_pulse", bus.vehicle_pulse, 1);
    check("arr_e5_count", bus.car_count, 1);
    check("arr_e5_req", bus.car_req, 1);
    step();
    check("arr_e6_pulse", bus.vehicle_pulse, 0);
    repeat (13) step();
    @(negedge clk) bus.sensor_raw = 1'b0;
    repeat (10) @(negedge clk);
    check("dep_count", bus.car_count, 1);
    bus.serve_ack = 1'b1;
    @(negedge clk) bus.serve_ack = 1'b0;
    check("ack_count", bus.car_count, 0);
    check("ack_req", bus.car_req, 0);

    // glitches of 1..3 cycles are rejected
    p0 = pulse_cnt;
    for (int w = 1; w <= 3; w++) begin
      bus.sensor_raw = 1'b1;
      repeat (w) @(negedge clk);
      bus.sensor_raw = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("glitch_pulses", 32'(pulse_cnt - p0), 0);
    check("glitch_count", bus.car_count, 0);

    // exactly DB cycles is accepted
    bus.sensor_raw = 1'b1;
    repeat (4) @(negedge clk);
    bus.sensor_raw = 1'b0;
    repeat (10) @(negedge clk);
    check("edge4_count", bus.car_count, 1);
    bus.serve_ack = 1'b1;
    @(negedge clk) bus.serve_ack = 1'b0;

    // saturation after 17 arrivals
    for (int i = 0; i < 17; i++) begin
      bus.sensor_raw = 1'b1;
      repeat (8) @(negedge clk);
      bus.sensor_raw = 1'b0;
      repeat (8) @(negedge clk);
    end
    check("sat_count", bus.car_count, 15);

    // serve_ack coincident with the 18th arrival
    bus.sensor_raw = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) bus.serve_ack = 1'b1;
    step();
    check("sim_pulse", bus.vehicle_pulse, 1);
    check("sim_count", bus.car_count, 1);
    @(negedge clk) bus.serve_ack = 1'b0;
    repeat (3) @(negedge clk);
    bus.sensor_raw = 1'b0;
    repeat (8) @(negedge clk);
    bus.serve_ack = 1'b1;
    @(negedge clk) bus.serve_ack = 1'b0;

    // stuck sensor: fault at edge 5 + 200
    bus.sensor_raw = 1'b1;
    repeat (205) @(posedge clk);
    #1;
    check("stuck_pre_fault", bus.fault, 0);
    step();
    check("stuck_fault", bus.fault, 1);
    check("stuck_req", bus.car_req, 1);
    @(negedge clk) bus.serve_ack = 1'b1;
    @(negedge clk) bus.serve_ack = 1'b0;
    check("stuck_ack_req", bus.car_req, 1);
    check("stuck_ack_count", bus.car_count, 0);
    check("stuck_ack_fault", bus.fault, 1);
    bus.sensor_raw = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("clr_e4_fault", bus.fault, 1);
    step();
    check("clr_e5_fault", bus.fault, 0);
    check("clr_e5_req", bus.car_req, 0);

    // enable freeze mid-debounce (two samples accumulated)
    @(negedge clk) bus.sensor_raw = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) bus.ena = 1'b0;
    p0 = pulse_cnt;
    repeat (10) @(negedge clk);
    check("frz_pulses", 32'(pulse_cnt - p0), 0);
    check("frz_count", bus.car_count, 0);
    bus.ena = 1'b1;
    step();
    check("resume1_pulse", bus.vehicle_pulse, 0);
    step();
    check("resume2_pulse", bus.vehicle_pulse, 1);
    check("resume2_count", bus.car_count, 1);
    @(negedge clk);
    bus.ena = 1'b0;
    bus.serve_ack = 1'b1;
    @(negedge clk);
    bus.serve_ack = 1'b0;
    bus.ena = 1'b1;
    check("frz_ack_count", bus.car_count, 1);
    bus.serve_ack = 1'b1;
    @(negedge clk) bus.serve_ack = 1'b0;
    check("en_ack_count", bus.car_count, 0);
    bus.sensor_raw = 1'b0;
    repeat (10) @(negedge clk);

    // async reset mid-occupancy with three vehicles queued
    for (int i = 0; i < 2; i++) begin
      bus.sensor_raw = 1'b1;
      repeat (8) @(negedge clk);
      bus.sensor_raw = 1'b0;
      repeat (8) @(negedge clk);
    end
    bus.sensor_raw = 1'b1;
    repeat (8) @(negedge clk);
    check("pre_rst_count", bus.car_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", bus.car_count, 0);
    check("arst_req", bus.car_req, 0);
    check("arst_pulse", bus.vehicle_pulse, 0);
    check("arst_fault", bus.fault, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rerun_e4_count", bus.car_count, 0);
    step();
    check("rerun_e5_pulse", bus.vehicle_pulse, 1);
    check("rerun_e5_count", bus.car_count, 1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
